// File: rtl/hwag_cfg_pkg.sv
// hwag_cfg_pkg: shared types and constants for the hwag configuration sequencer
package hwag_cfg_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;
    localparam int HWATHNB = 4;
    localparam int HWASTWD = 5;
    localparam int HWAATOPL = 6;
    localparam int HWACR0 = 63;
    localparam int HWATHVL = 70;
    localparam int HWAIGNCHRGL = 127;
    localparam int HWAIGNANGL = 129;
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, VERIFY, RUN, ERROR} state_t;
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } cfg_entry_t;
    function automatic cfg_entry_t mk_entry(int a, int d);
        return '{addr: AW_DEF'(a), data: DW_DEF'(d)};
    endfunction
endpackage

// File: rtl/hwag_cfg_rom.sv
// hwag_cfg_rom: combinational lookup of the default register table
module hwag_cfg_rom
    import hwag_cfg_pkg::*;
#(
    parameter int IW = 8
) (
    input  logic [IW-1:0] idx_i,
    output cfg_entry_t    entry_o
);
    // table entries in ascending write order; indices past the end read as zero
    always_comb begin
        case (idx_i)
            IW'(0):  entry_o = mk_entry(0, 128);
            IW'(1):  entry_o = mk_entry(1, 0);
            IW'(2):  entry_o = mk_entry(2, 65535);
            IW'(3):  entry_o = mk_entry(3, 0);
            IW'(4):  entry_o = mk_entry(HWATHNB, 57);
            IW'(5):  entry_o = mk_entry(HWASTWD, 4);
            IW'(6):  entry_o = mk_entry(HWAATOPL, 3839);
            IW'(7):  entry_o = mk_entry(HWACR0, 7);
            IW'(8):  entry_o = mk_entry(65, 2);
            IW'(9):  entry_o = mk_entry(HWATHVL, 2);
            IW'(10): entry_o = mk_entry(HWAIGNCHRGL, 1024);
            IW'(11): entry_o = mk_entry(HWAIGNANGL, 3830);
            default: entry_o = '0;
        endcase
    end
endmodule

// File: rtl/hwag_cfg_sequencer.sv
// hwag_cfg_sequencer: clears and loads the register file, then arbitrates host access; HWAG_CFG_VERIFY_EN adds read-back verify
module hwag_cfg_sequencer
    import hwag_cfg_pkg::*;
#(
    parameter int REG_CNT = 131,
    parameter int TBL_CNT = 12,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_reload,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [DW-1:0] reg_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid
);
    localparam int IW = $clog2((REG_CNT > TBL_CNT ? REG_CNT : TBL_CNT) + 1);

    state_t        state_q, state_d, eff_st;
    logic [IW-1:0] idx_q, idx_d, eff_idx;
    logic          reload, host_ok, err_q, err_d, pend_q, pend_d, rvalid_q;
    logic          we_q, we_d, re_q, re_d, gnt_q, gnt_d, busy_q, busy_d, done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q;
    cfg_entry_t    entry;

    // a reload acts in the same cycle as if CLEAR index 0 were already current
    assign reload  = cfg_reload && state_q != IDLE;
    assign eff_st  = reload ? CLEAR : state_q;
    assign eff_idx = reload ? '0 : idx_q;
    assign host_ok = (eff_st == RUN || eff_st == ERROR) && host_req && !gnt_q;

    hwag_cfg_rom #(.IW(IW)) u_rom (.idx_i(eff_idx), .entry_o(entry));

`ifdef HWAG_CFG_VERIFY_EN
    logic [DW-1:0] exp_q;
    logic          mism;
    assign mism  = state_q == VERIFY && idx_q != '0 && reg_rdata != exp_q;
    assign err_d = !reload && (err_q || mism);
    // remember the table data of the read in flight for next-cycle compare
    always_ff @(posedge clk) exp_q <= rst ? '0 : entry.data;
`else
    assign err_d = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // next state: terminal index of each phase selects the following phase
    always_comb begin
        state_d = eff_st;
        idx_d   = '0;
        case (eff_st)
            IDLE: state_d = CLEAR;
            CLEAR: begin
                state_d = eff_idx == IW'(REG_CNT - 1) ? LOAD : CLEAR;
                idx_d   = eff_idx == IW'(REG_CNT - 1) ? '0 : eff_idx + 1'b1;
            end
            LOAD: begin
`ifdef HWAG_CFG_VERIFY_EN
                state_d = eff_idx == IW'(TBL_CNT - 1) ? VERIFY : LOAD;
`else
                state_d = eff_idx == IW'(TBL_CNT - 1) ? RUN : LOAD;
`endif
                idx_d   = eff_idx == IW'(TBL_CNT - 1) ? '0 : eff_idx + 1'b1;
            end
`ifdef HWAG_CFG_VERIFY_EN
            VERIFY: begin
                state_d = eff_idx != IW'(TBL_CNT) ? VERIFY : (err_q || mism) ? ERROR : RUN;
                idx_d   = eff_idx != IW'(TBL_CNT) ? eff_idx + 1'b1 : '0;
            end
`endif
            default: ;
        endcase
    end

    // bus and status values for the next cycle
    always_comb begin
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        gnt_d   = host_ok;
        pend_d  = host_ok && !host_we;
        busy_d  = eff_st == CLEAR || eff_st == LOAD || eff_st == VERIFY;
        done_d  = eff_st == RUN;
        case (eff_st)
            CLEAR: begin
                we_d   = 1'b1;
                addr_d = AW'(eff_idx);
            end
            LOAD: begin
                we_d    = 1'b1;
                addr_d  = entry.addr;
                wdata_d = entry.data;
            end
            VERIFY: begin
                re_d   = eff_idx < IW'(TBL_CNT);
                addr_d = entry.addr;
            end
            default: if (host_ok) begin
                we_d    = host_we;
                re_d    = !host_we;
                addr_d  = host_addr;
                wdata_d = host_wdata;
            end
        endcase
    end

    // registered outputs; a granted read returns data the cycle after its grant
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            gnt_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
            rvalid_q <= pend_q;
            rdata_q  <= pend_q ? reg_rdata : rdata_q;
        end
    end

    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_we      = we_q;
    assign reg_re      = re_q;
    assign host_gnt    = gnt_q;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
    assign cfg_busy    = busy_q;
    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
endmodule

// File: tb/tb_hwag_cfg_sequencer.sv
// tb_hwag_cfg_sequencer: randomized self-checking bench with a register-file model and a shadow reference
module tb_hwag_cfg_sequencer;
    localparam int REG = 131;
    localparam int TBL = 12;
`ifdef HWAG_CFG_VERIFY_EN
    localparam int VLEN = TBL + 1;
`else
    localparam int VLEN = 0;
`endif
    localparam int DONE_P = REG + TBL + 1 + VLEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_reload = 1'b0;
    logic        cfg_busy, cfg_done, cfg_err;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we, reg_re;
    logic [15:0] reg_rdata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = 8'd0;
    logic [15:0] host_wdata = 16'd0;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;

    logic [15:0] mem [256];
    logic [15:0] shadow [256];
    bit          force63 = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          tbl_a [TBL] = '{0, 1, 2, 3, 4, 5, 6, 63, 65, 70, 127, 129};
    int          tbl_d [TBL] = '{128, 0, 65535, 0, 57, 4, 3839, 7, 2, 2, 1024, 3830};

    hwag_cfg_sequencer dut (
        .clk(clk), .rst(rst), .cfg_reload(cfg_reload),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reg_we) mem[reg_addr] <= reg_wdata;

    always_comb reg_rdata = (force63 && reg_addr == 8'd63) ? 16'd6 : mem[reg_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [30:0] act_vec();
        return {reg_we, reg_re, reg_addr, reg_wdata, cfg_busy, cfg_done, cfg_err, host_gnt, host_rvalid};
    endfunction

    // expected bus/status p cycles into a boot sequence with no host traffic
    function automatic logic [30:0] exp_seq(int p);
        logic we, re, busy, done;
        logic [7:0] a;
        logic [15:0] d;
        we = 0; re = 0; busy = 0; done = 0; a = 0; d = 0;
        if (p >= 1 && p <= REG) begin
            we = 1; busy = 1; a = 8'(p - 1);
        end else if (p > REG && p <= REG + TBL) begin
            we = 1; busy = 1; a = 8'(tbl_a[p-REG-1]); d = 16'(tbl_d[p-REG-1]);
        end else if (p > REG + TBL && p < DONE_P) begin
            busy = 1;
            if (p <= REG + 2 * TBL) begin
                re = 1; a = 8'(tbl_a[p-REG-TBL-1]);
            end
        end else if (p >= DONE_P) done = 1;
        return {we, re, a, d, busy, done, 3'b000};
    endfunction

    task automatic init_shadow();
        for (int i = 0; i < 256; i++) shadow[i] = 16'd0;
        for (int t = 0; t < TBL; t++) shadow[tbl_a[t]] = 16'(tbl_d[t]);
    endtask

    task automatic start();
        rst = 1; cfg_reload = 0; host_req = 0;
        step();
        step();
        rst = 0;
        init_shadow();
    endtask

    task automatic test_reset();
        host_req = 1; host_we = 1; host_addr = 8'($urandom); host_wdata = 16'($urandom); cfg_reload = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({act_vec(), host_rdata} !== 47'd0) begin
                errors++;
                $display("FAIL reset k=%0d: got %h required 0", k, {act_vec(), host_rdata});
            end
        end
        host_req = 0; cfg_reload = 0;
    endtask

    task automatic test_boot();
        logic [15:0] wd;
        start();
        wd = 16'($urandom);
        for (int p = 0; p < DONE_P; p++) begin
            step();
            checks++;
            if (act_vec() !== exp_seq(p)) begin
                errors++;
                $display("FAIL boot p=%0d: got %h required %h", p, act_vec(), exp_seq(p));
            end
            if (p == 10) begin
                host_req = 1; host_we = 0; host_addr = 8'd5; host_wdata = wd;
            end
        end
        step();
        checks++;
        if (act_vec() !== {1'b0, 1'b1, 8'd5, wd, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL first_grant: got %h required %h", act_vec(), {1'b0, 1'b1, 8'd5, wd, 5'b01010});
        end
        host_req = 0;
        step();
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== shadow[5] || host_gnt !== 1'b0) begin
            errors++;
            $display("FAIL first_read: rvalid=%b rdata=%h gnt=%b required 1 %h 0", host_rvalid, host_rdata, host_gnt, shadow[5]);
        end
    endtask

    task automatic test_host_rand();
        bit we, got;
        int a, lat;
        logic [15:0] d;
        for (int n = 0; n < 22; n++) begin
            we = (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : 1'($urandom);
            a = (n < 2) ? 4 : int'($urandom_range(0, REG - 1));
            d = (n == 0) ? 16'd60 : 16'($urandom);
            host_req = 1; host_we = we; host_addr = 8'(a); host_wdata = d;
            got = 0; lat = 0;
            for (int k = 0; k < 4 && !got; k++) begin
                step();
                lat = k + 1;
                got = host_gnt;
            end
            checks++;
            if (!got || lat != 1 || reg_addr !== 8'(a) || reg_we !== we || reg_re !== !we || (we && reg_wdata !== d)) begin
                errors++;
                $display("FAIL host_grant n=%0d: gnt=%b lat=%0d addr=%h we=%b re=%b wdata=%h required addr=%h we=%b lat=1",
                         n, got, lat, reg_addr, reg_we, reg_re, reg_wdata, 8'(a), we);
            end
            host_req = 0;
            if (we) shadow[a] = d;
            step();
            checks++;
            if (host_rvalid !== !we || (!we && host_rdata !== shadow[a])) begin
                errors++;
                $display("FAIL host_data n=%0d: rvalid=%b rdata=%h required rvalid=%b rdata=%h", n, host_rvalid, host_rdata, !we, shadow[a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        host_req = 1; host_we = 0; host_addr = 8'd6;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (host_gnt !== (k % 2 == 0) || host_rvalid !== (k % 2 == 1) || (k % 2 == 1 && host_rdata !== shadow[6])) begin
                errors++;
                $display("FAIL back_to_back k=%0d: gnt=%b rvalid=%b rdata=%h required gnt=%b rvalid=%b rdata=%h",
                         k, host_gnt, host_rvalid, host_rdata, k % 2 == 0, k % 2 == 1, shadow[6]);
            end
        end
        host_req = 0;
        step();
    endtask

    task automatic test_reload_run();
        logic [15:0] old5;
        old5 = shadow[5];
        host_req = 1; host_we = 0; host_addr = 8'd5;
        step();
        checks++;
        if (host_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reload_run_grant: gnt=%b required 1", host_gnt);
        end
        cfg_reload = 1; host_we = 1; host_addr = 8'd100; host_wdata = 16'h1234;
        step();
        cfg_reload = 0;
        checks++;
        if (act_vec() !== (exp_seq(1) | 31'd1) || host_rdata !== old5) begin
            errors++;
            $display("FAIL reload_run: got %h rdata=%h required %h rdata=%h", act_vec(), host_rdata, exp_seq(1) | 31'd1, old5);
        end
        init_shadow();
        for (int p = 2; p < DONE_P; p++) begin
            step();
            checks++;
            if (act_vec() !== exp_seq(p)) begin
                errors++;
                $display("FAIL reload_run_seq p=%0d: got %h required %h", p, act_vec(), exp_seq(p));
            end
        end
        step();
        checks++;
        if (host_gnt !== 1'b1 || reg_we !== 1'b1 || reg_addr !== 8'd100 || reg_wdata !== 16'h1234 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL held_write: gnt=%b we=%b addr=%h wdata=%h done=%b required 1 1 64 1234 1", host_gnt, reg_we, reg_addr, reg_wdata, cfg_done);
        end
        host_req = 0;
        shadow[100] = 16'h1234;
        step();
        host_req = 1; host_we = 0; host_addr = 8'd100;
        step();
        host_req = 0;
        step();
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== shadow[100]) begin
            errors++;
            $display("FAIL held_write_read: rvalid=%b rdata=%h required 1 %h", host_rvalid, host_rdata, shadow[100]);
        end
    endtask

    task automatic test_reload_load();
        start();
        for (int p = 0; p <= REG + 6; p++) begin
            step();
            checks++;
            if (act_vec() !== exp_seq(p)) begin
                errors++;
                $display("FAIL reload_load_pre p=%0d: got %h required %h", p, act_vec(), exp_seq(p));
            end
        end
        cfg_reload = 1;
        step();
        cfg_reload = 0;
        for (int p = 1; p <= DONE_P; p++) begin
            if (p > 1) step();
            checks++;
            if (act_vec() !== exp_seq(p)) begin
                errors++;
                $display("FAIL reload_load p=%0d: got %h required %h", p, act_vec(), exp_seq(p));
            end
        end
    endtask

    task automatic test_rst_mid();
        start();
        for (int p = 0; p <= 40; p++) step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if ({act_vec(), host_rdata} !== 47'd0) begin
            errors++;
            $display("FAIL rst_mid: got %h required 0", {act_vec(), host_rdata});
        end
        for (int p = 0; p <= DONE_P; p++) begin
            step();
            checks++;
            if (act_vec() !== exp_seq(p)) begin
                errors++;
                $display("FAIL rst_restart p=%0d: got %h required %h", p, act_vec(), exp_seq(p));
            end
        end
    endtask

`ifdef HWAG_CFG_VERIFY_EN
    task automatic test_verify();
        force63 = 1;
        start();
        for (int p = 0; p <= REG + TBL + 8; p++) begin
            step();
            checks++;
            if (act_vec() !== exp_seq(p)) begin
                errors++;
                $display("FAIL verify_seq p=%0d: got %h required %h", p, act_vec(), exp_seq(p));
            end
        end
        for (int p = REG + TBL + 9; p <= DONE_P; p++) step();
        checks++;
        if (cfg_err !== 1'b1 || cfg_done !== 1'b0 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL verify_err: err=%b done=%b busy=%b required 1 0 0", cfg_err, cfg_done, cfg_busy);
        end
        host_req = 1; host_we = 0; host_addr = 8'd4;
        step();
        host_req = 0;
        checks++;
        if (host_gnt !== 1'b1) begin
            errors++;
            $display("FAIL error_grant: gnt=%b required 1", host_gnt);
        end
        step();
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 16'd57 || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL error_read: rvalid=%b rdata=%h err=%b required 1 0039 1", host_rvalid, host_rdata, cfg_err);
        end
        cfg_reload = 1;
        step();
        cfg_reload = 0;
        force63 = 0;
        checks++;
        if (cfg_err !== 1'b0 || cfg_busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_clears_err: err=%b busy=%b required 0 1", cfg_err, cfg_busy);
        end
        for (int p = 2; p <= DONE_P; p++) begin
            step();
            checks++;
            if (act_vec() !== exp_seq(p)) begin
                errors++;
                $display("FAIL verify_clean p=%0d: got %h required %h", p, act_vec(), exp_seq(p));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_boot();
        test_host_rand();
        test_back_to_back();
        test_reload_run();
        test_reload_load();
        test_rst_mid();
`ifdef HWAG_CFG_VERIFY_EN
        test_verify();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
